// File: rtl/demux_1x4_stream_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
// Channel select type, slot states and the select decoder.
package demux_pkg;

    localparam int NUM_CH     = 4;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] ch_sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(
        input ch_sel_t sel
    );
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_1x4_stream_if.sv
// Upstream and per-channel downstream handshake bundle for the
// 1-to-4 stream demultiplexer.
interface demux_1x4_stream_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                       in_valid;
    ch_sel_t                    in_sel;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ready;
    logic [NUM_CH-1:0]          out_valid;
    logic [NUM_CH*DATA_W-1:0]   out_data;
    logic [NUM_CH-1:0]          out_ready;
    logic                       busy;

    modport dut (
        input  in_valid,
        input  in_sel,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output busy
    );

    modport tb (
        output in_valid,
        output in_sel,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/demux_1x4_stream_slot.sv
// One-entry holding slot for a single output channel.
// A load always wins over a drain in the same cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    slot_state_t       state;
    slot_state_t       state_nxt;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Word register only moves on a load; empty slots keep stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!load && out_ready) begin
                    state_nxt = SLOT_EMPTY;
                end
            end
        endcase
    end

    assign out_valid = (state == SLOT_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with one slot per channel
// and independent per-channel backpressure.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic            clk,
    input logic            rst_n,
    demux_1x4_stream_if.dut bus
);

    logic [NUM_CH-1:0] valid_vec;
    logic [NUM_CH-1:0] load_vec;
    logic              accept;

    logic [DATA_W-1:0] data_vec [NUM_CH];

    // Only the addressed slot gates the upstream; others never stall it.
    assign bus.in_ready = !valid_vec[bus.in_sel]
                       || bus.out_ready[bus.in_sel];

    assign accept   = bus.in_valid && bus.in_ready;
    assign load_vec = sel_onehot(bus.in_sel) & {NUM_CH{accept}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_vec[i]),
            .load_data(bus.in_data),
            .out_valid(valid_vec[i]),
            .out_data (data_vec[i]),
            .out_ready(bus.out_ready[i])
        );

        assign bus.out_data[i*DATA_W +: DATA_W] = data_vec[i];
    end

    assign bus.out_valid = valid_vec;
    assign bus.busy      = |valid_vec;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed and randomized bench for the 1-to-4 stream demultiplexer.
// Per-channel slot model checks ordering, drops and duplicates.
module tb_demux_1x4_stream;
    import demux_pkg::*;

    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic stab_en;

    demux_1x4_stream_if #(.DATA_W(DW)) bus ();

    demux_1x4_stream #(
        .DATA_W(DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream must hold a pending word stable until it is taken.
    logic    pv;
    logic    pacc;
    ch_sel_t ps;
    logic [DW-1:0] pd;
    initial begin
        pv   = 1'b0;
        pacc = 1'b0;
        ps   = '0;
        pd   = '0;
    end
    always @(posedge clk) begin
        if (stab_en && pv && !pacc) begin
            assert (bus.in_valid && bus.in_sel == ps && bus.in_data == pd)
            else $error("upstream word changed before accept");
        end
        pv   = bus.in_valid;
        pacc = bus.in_valid && bus.in_ready;
        ps   = bus.in_sel;
        pd   = bus.in_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    logic [NUM_CH-1:0] mv;
    logic [DW-1:0]     md [NUM_CH];
    logic              acc;
    logic              exp_ready;

    initial begin
        checks        = 0;
        failures      = 0;
        stab_en       = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;

        // 1: reset state, then one word into ch2 with no consumers
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data", bus.out_data, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'hA5;
        @(negedge clk);
        chk("t1_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(bus.out_valid), 32'h4);
        chk("t1_data", 32'(bus.out_data[23:16]), 32'hA5);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        repeat (3) tick();
        @(negedge clk);
        chk("t1_hold", {bus.out_valid, 20'h0, bus.out_data[23:16]},
            {4'h4, 20'h0, 8'hA5});

        // 2: ch2 stalled blocks its own traffic but not ch0
        tick();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'h3C;
        @(negedge clk);
        chk("t2_block", 32'(bus.in_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("t2_nochg", 32'(bus.out_data[23:16]), 32'hA5);
        bus.in_sel  = 2'd0;
        bus.in_data = 8'h11;
        #1;
        chk("t2_ready0", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid", 32'(bus.out_valid), 32'h5);
        chk("t2_data0", 32'(bus.out_data[7:0]), 32'h11);

        // 3: back-to-back stream into ch1 with its consumer ready
        bus.out_ready = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'd1;
            bus.in_data  = 8'(k);
            @(negedge clk);
            chk("t3_ready", 32'(bus.in_ready), 32'h1);
            if (k > 1) begin
                chk("t3_data", {23'h0, bus.out_valid[1], bus.out_data[15:8]},
                    {23'h0, 1'b1, 8'(k - 1)});
            end
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_last", {23'h0, bus.out_valid[1], bus.out_data[15:8]},
            {23'h0, 1'b1, 8'h08});
        tick();
        @(negedge clk);
        chk("t3_drained", 32'(bus.out_valid), 32'h5);

        // 4: simultaneous drain and refill of ch3
        bus.out_ready = 4'b0101;
        tick();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 8'h77;
        @(negedge clk);
        chk("t4_empty", 32'(bus.out_valid), 32'h0);
        tick();
        bus.out_ready = 4'b1000;
        bus.in_data   = 8'h88;
        @(negedge clk);
        chk("t4_old", {bus.out_valid, 20'h0, bus.out_data[31:24]},
            {4'h8, 20'h0, 8'h77});
        chk("t4_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        @(negedge clk);
        chk("t4_new", {bus.out_valid, 20'h0, bus.out_data[31:24]},
            {4'h8, 20'h0, 8'h88});

        // 5: asynchronous reset with all slots full
        bus.out_ready = 4'hF;
        tick();
        bus.out_ready = 4'h0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(c);
            bus.in_data  = 8'(8'h10 + c);
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_full", 32'(bus.out_valid), 32'hF);
        chk("t5_data", bus.out_data, 32'h13121110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid", 32'(bus.out_valid), 32'h0);
        chk("t5_rdata", bus.out_data, 32'h0);
        chk("t5_rbusy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 8'h55;
        @(negedge clk);
        chk("t5_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_resume", {bus.out_valid, 20'h0, bus.out_data[7:0]},
            {4'h1, 20'h0, 8'h55});
        bus.out_ready = 4'hF;
        tick();
        bus.out_ready = 4'h0;

        // 6: random traffic against a per-channel slot model
        mv      = '0;
        acc     = 1'b0;
        stab_en = 1'b1;
        for (int i = 0; i < NUM_CH; i++) md[i] = '0;
        for (int n = 0; n < 10000; n++) begin
            tick();
            if (!(bus.in_valid && !acc)) begin
                bus.in_valid = ($urandom_range(3) != 0);
                bus.in_sel   = 2'($urandom_range(3));
                bus.in_data  = 8'($urandom_range(255));
            end
            bus.out_ready = 4'($urandom_range(15));
            @(negedge clk);
            exp_ready = !mv[bus.in_sel] || bus.out_ready[bus.in_sel];
            chk("r_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("r_valid", 32'(bus.out_valid), 32'(mv));
            for (int i = 0; i < NUM_CH; i++) begin
                if (mv[i] && bus.out_ready[i]) begin
                    chk("r_data", 32'(bus.out_data[i*DW +: DW]), 32'(md[i]));
                    mv[i] = 1'b0;
                end
            end
            acc = bus.in_valid && exp_ready;
            if (acc) begin
                mv[bus.in_sel] = 1'b1;
                md[bus.in_sel] = bus.in_data;
            end
        end
        tick();
        bus.in_valid  = 1'b0;
        stab_en       = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
